// File: rtl/apb_pkg.sv
// Shared APB definitions for the RAM-backed completers.
// Bus widths and the completer FSM state type.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_ram_core.sv
// Byte RAM behind an APB completer.
// Synchronous write port, asynchronous read port.
module apb_ram_core #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_ram.sv
// APB completer with local byte RAM, fixed wait states,
// out-of-range error response and saturating error counter.
module apb_slave_ram
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_t        state;
  logic [3:0]        cnt;
  logic [AW-1:0]     addr_q;
  logic              wr_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata;
  logic              setup;
  logic              done;
  logic              ram_we;
  logic              in_range;

  assign setup    = PSEL & ~PENABLE;
  assign in_range = int'(PADDR) < DEPTH;

  // Completion is gated by reset so a reset edge never commits a write.
  assign done = (state == ACCESS) & PSEL & PENABLE
              & (cnt == 4'd0) & ~PRESET;
  assign ram_we = done & wr_q & ~err_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      err_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state   <= ACCESS;
            cnt     <= 4'(WAIT_CYCLES);
            addr_q  <= PADDR[AW-1:0];
            wr_q    <= PWRITE;
            err_q   <= ~in_range;
            wdata_q <= PWDATA;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (setup) begin
            cnt     <= 4'(WAIT_CYCLES);
            addr_q  <= PADDR[AW-1:0];
            wr_q    <= PWRITE;
            err_q   <= ~in_range;
            wdata_q <= PWDATA;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
            if (err_q && err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_ram_core #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (PCLK),
    .we   (ram_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rdata(rdata)
  );

  assign PREADY  = done;
  assign PSLVERR = done & err_q;
  assign PRDATA  = (done & ~wr_q & ~err_q) ? rdata : '0;

endmodule
